// File: rtl/serial_add_seq_pkg.sv
// Shared types and helpers for the serial (slice-per-cycle) wide adder.
package serial_add_seq_pkg;

   // Sequencer states: accept operands, add one slice per cycle, present the result.
   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } state_e;

   // Number of slice additions needed for one full-width sum.
   function automatic int unsigned nslice(input int unsigned width, input int unsigned slice);
      return (slice == 0) ? 1 : width / slice;
   endfunction

   // Slice counter width; at least one bit so a single-slice build still has a counter.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/serial_add_seq_add_slice.sv
// Narrow combinational adder slice: {cout, sum} = a + b + cin over SLICE bits.
module add_slice #(
   parameter int unsigned SLICE = 2
) (
   input  logic [SLICE-1:0] a_i,
   input  logic [SLICE-1:0] b_i,
   input  logic             cin_i,
   output logic [SLICE-1:0] sum_o,
   output logic             cout_o
);

   logic [SLICE:0] full;

   // One extra bit holds the carry out of the slice.
   always_comb begin
      full   = {1'b0, a_i} + {1'b0, b_i} + {{SLICE{1'b0}}, cin_i};
      sum_o  = full[SLICE-1:0];
      cout_o = full[SLICE];
   end

endmodule

// File: rtl/serial_add_seq.sv
// Multi-cycle wide adder: operands are accepted over a valid/ready handshake and summed SLICE bits
// per cycle through one narrow add_slice with a registered carry. The result is held until the
// consumer takes it.
// Optional feature: define SERIAL_ADD_SEQ_OVF_EN to add io_out_ovf (two's-complement overflow).
module serial_add_seq
   import serial_add_seq_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned SLICE = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             io_in_valid,
   output logic             io_in_ready,
   input  logic [WIDTH-1:0] io_in_lhs,
   input  logic [WIDTH-1:0] io_in_rhs,
   input  logic             io_in_cin,
   output logic             io_out_valid,
   input  logic             io_out_ready,
   output logic [WIDTH-1:0] io_out_sum,
`ifdef SERIAL_ADD_SEQ_OVF_EN
   output logic             io_out_ovf,
`endif
   output logic             io_out_cout
);

   localparam int unsigned NSLICE = nslice(WIDTH, SLICE);
   localparam int unsigned CW     = cnt_width(NSLICE);
   localparam logic [CW-1:0] CntLast = CW'(NSLICE - 1);

   // Reject configurations the slice sequencing cannot cover exactly.
   if (SLICE == 0) begin : g_bad_slice
      $error("serial_add_seq: SLICE must be at least 1");
   end else if (SLICE > WIDTH || (WIDTH % SLICE) != 0) begin : g_bad_width
      $error("serial_add_seq: WIDTH must be a multiple of SLICE and SLICE <= WIDTH");
   end

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic [WIDTH-1:0] lhs_q, lhs_d;
   logic [WIDTH-1:0] rhs_q, rhs_d;

   logic [SLICE-1:0] slice_sum;
   logic             slice_cout;
   logic             accept;

   assign accept = io_in_valid && (state_q == StIdle);

   add_slice #(
      .SLICE (SLICE)
   ) u_add_slice (
      .a_i    (lhs_q[SLICE-1:0]),
      .b_i    (rhs_q[SLICE-1:0]),
      .cin_i  (carry_q),
      .sum_o  (slice_sum),
      .cout_o (slice_cout)
   );

   // State and datapath registers; reset drops any in-flight operation.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         sum_q   <= '0;
         lhs_q   <= '0;
         rhs_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         sum_q   <= sum_d;
         lhs_q   <= lhs_d;
         rhs_q   <= rhs_d;
      end
   end

   // Next-state: load operands on accept, add one slice per RUN cycle, hold in DONE.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      sum_d   = sum_q;
      lhs_d   = lhs_q;
      rhs_d   = rhs_q;

      unique case (state_q)
         StIdle: begin
            if (accept) begin
               lhs_d   = io_in_lhs;
               rhs_d   = io_in_rhs;
               carry_d = io_in_cin;
               cnt_d   = '0;
               sum_d   = '0;
               state_d = StRun;
            end
         end
         StRun: begin
            // Operands shift right so the slice always sees the next unconsumed bits.
            sum_d[32'(cnt_q) * SLICE +: SLICE] = slice_sum;
            carry_d = slice_cout;
            lhs_d   = lhs_q >> SLICE;
            rhs_d   = rhs_q >> SLICE;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == CntLast) begin
               state_d = StDone;
            end
         end
         StDone: begin
            if (io_out_ready) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Handshake flags decode straight from state; result comes from registers only.
   always_comb begin
      io_in_ready  = (state_q == StIdle);
      io_out_valid = (state_q == StDone);
      io_out_sum   = sum_q;
      io_out_cout  = carry_q;
   end

`ifdef SERIAL_ADD_SEQ_OVF_EN
   logic lhs_msb_q, lhs_msb_d;
   logic rhs_msb_q, rhs_msb_d;

   // Operand sign bits captured at accept, since the shift registers lose them during RUN.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lhs_msb_q <= 1'b0;
         rhs_msb_q <= 1'b0;
      end else begin
         lhs_msb_q <= lhs_msb_d;
         rhs_msb_q <= rhs_msb_d;
      end
   end

   // Sign latch update and overflow flag, qualified by DONE.
   always_comb begin
      lhs_msb_d  = lhs_msb_q;
      rhs_msb_d  = rhs_msb_q;
      if (accept) begin
         lhs_msb_d = io_in_lhs[WIDTH-1];
         rhs_msb_d = io_in_rhs[WIDTH-1];
      end
      io_out_ovf = (state_q == StDone) && (lhs_msb_q == rhs_msb_q) &&
                   (sum_q[WIDTH-1] != lhs_msb_q);
   end
`endif

endmodule

// File: tb/tb_serial_add_seq.sv
// Self-checking bench for serial_add_seq: directed vector table on WIDTH=8/SLICE=2, hand-written
// backpressure and mid-operation reset sequences, plus random sweeps on SLICE=1/4/8 instances.
module tb_serial_add_seq;

   localparam int unsigned NSLICE = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic       rst_sw;
   logic       in_valid, in_ready, in_cin;
   logic [7:0] in_lhs, in_rhs;
   logic       out_valid, out_ready, out_cout;
   logic [7:0] out_sum;
`ifdef SERIAL_ADD_SEQ_OVF_EN
   logic       out_ovf;
`endif

   int n_pass     = 0;
   int n_total    = 0;
   int sweep_done = 0;

   always #5 clk = ~clk;

   serial_add_seq #(
      .WIDTH (8),
      .SLICE (2)
   ) u_dut (
      .clk          (clk),
      .reset        (reset),
      .io_in_valid  (in_valid),
      .io_in_ready  (in_ready),
      .io_in_lhs    (in_lhs),
      .io_in_rhs    (in_rhs),
      .io_in_cin    (in_cin),
      .io_out_valid (out_valid),
      .io_out_ready (out_ready),
      .io_out_sum   (out_sum),
`ifdef SERIAL_ADD_SEQ_OVF_EN
      .io_out_ovf   (out_ovf),
`endif
      .io_out_cout  (out_cout)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   function automatic logic get_ovf();
`ifdef SERIAL_ADD_SEQ_OVF_EN
      return out_ovf;
`else
      return 1'b0;
`endif
   endfunction

   // Present one request, then wait (bounded) for DONE; returns the cycles from accept to valid.
   task automatic start_op(input logic [7:0] l, input logic [7:0] r, input logic c,
                           output int lat);
      @(negedge clk);
      check("in_ready_before_accept", 32'(in_ready), 32'd1);
      in_lhs = l; in_rhs = r; in_cin = c; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 50) begin
         @(posedge clk);
         @(negedge clk);
         lat++;
      end
   endtask

   // Accept the result and confirm the block is back in IDLE.
   task automatic finish_op();
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      check("out_valid_after_take", 32'(out_valid), 32'd0);
      check("in_ready_after_take", 32'(in_ready), 32'd1);
   endtask

   typedef struct {
      logic [7:0] lhs;
      logic [7:0] rhs;
      logic       cin;
      logic [7:0] sum;
      logic       cout;
      logic       ovf;
   } vec_t;

   vec_t vecs[10];

   initial begin
      int lat;
      int t;

      vecs[0] = '{8'h5A, 8'h3C, 1'b1, 8'h97, 1'b0, 1'b1};
      vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
      vecs[2] = '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0};
      vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
      vecs[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
      vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
      vecs[6] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
      vecs[7] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0};
      vecs[8] = '{8'h0F, 8'hF0, 1'b0, 8'hFF, 1'b0, 1'b0};
      vecs[9] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0};

      reset = 1'b0; rst_sw = 1'b0;
      in_valid = 1'b0; in_lhs = '0; in_rhs = '0; in_cin = 1'b0; out_ready = 1'b0;
      #1;
      check("reset_in_ready", 32'(in_ready), 32'd1);
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_sum", 32'(out_sum), 32'd0);
      check("reset_cout", 32'(out_cout), 32'd0);
      check("reset_ovf", 32'(get_ovf()), 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1; rst_sw = 1'b1;

      // Directed vector table.
      for (int i = 0; i < 10; i++) begin
         start_op(vecs[i].lhs, vecs[i].rhs, vecs[i].cin, lat);
         check($sformatf("vec%0d_latency", i), 32'(lat), 32'(NSLICE));
         check($sformatf("vec%0d_sum", i), 32'(out_sum), 32'(vecs[i].sum));
         check($sformatf("vec%0d_cout", i), 32'(out_cout), 32'(vecs[i].cout));
`ifdef SERIAL_ADD_SEQ_OVF_EN
         check($sformatf("vec%0d_ovf", i), 32'(out_ovf), 32'(vecs[i].ovf));
`endif
         finish_op();
      end

      // Backpressure: DONE held three cycles while new requests are offered and ignored.
      start_op(8'h5A, 8'h3C, 1'b1, lat);
      check("hold_latency", 32'(lat), 32'(NSLICE));
      for (int k = 0; k < 3; k++) begin
         in_lhs = 8'hFF; in_rhs = 8'hFF; in_cin = 1'b1; in_valid = 1'b1;
         @(posedge clk);
         @(negedge clk);
         check($sformatf("hold%0d_out_valid", k), 32'(out_valid), 32'd1);
         check($sformatf("hold%0d_sum", k), 32'(out_sum), 32'h97);
         check($sformatf("hold%0d_cout", k), 32'(out_cout), 32'd0);
         check($sformatf("hold%0d_in_ready", k), 32'(in_ready), 32'd0);
      end
      in_valid = 1'b0;
      finish_op();
      @(posedge clk);
      @(negedge clk);
      check("hold_no_reaccept", 32'(in_ready), 32'd1);

      // Reset asserted after two slices of an operation.
      @(negedge clk);
      in_lhs = 8'h5A; in_rhs = 8'h3C; in_cin = 1'b1; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_sum", 32'(out_sum), 32'd0);
      check("midrst_cout", 32'(out_cout), 32'd0);
      check("midrst_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      reset = 1'b1;
      start_op(8'h10, 8'h20, 1'b0, lat);
      check("postrst_latency", 32'(lat), 32'(NSLICE));
      check("postrst_sum", 32'(out_sum), 32'h30);
      check("postrst_cout", 32'(out_cout), 32'd0);
      finish_op();

      t = 0;
      while (sweep_done < 3 && t < 5000) begin
         @(posedge clk);
         t++;
      end
      check("sweeps_finished", 32'(sweep_done), 32'd3);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   // Random sweeps with backpressure on the other slice widths, against {cout,sum} = lhs+rhs+cin.
   for (genvar g = 0; g < 3; g++) begin : g_sweep
      localparam int unsigned SL = (g == 0) ? 1 : ((g == 1) ? 4 : 8);
      localparam int unsigned NS = 8 / SL;

      logic       v, ir, ovld, ordy, ci, co;
      logic [7:0] l, r, s;
`ifdef SERIAL_ADD_SEQ_OVF_EN
      logic       ovf;
`endif

      serial_add_seq #(
         .WIDTH (8),
         .SLICE (SL)
      ) u_dut (
         .clk          (clk),
         .reset        (rst_sw),
         .io_in_valid  (v),
         .io_in_ready  (ir),
         .io_in_lhs    (l),
         .io_in_rhs    (r),
         .io_in_cin    (ci),
         .io_out_valid (ovld),
         .io_out_ready (ordy),
         .io_out_sum   (s),
`ifdef SERIAL_ADD_SEQ_OVF_EN
         .io_out_ovf   (ovf),
`endif
         .io_out_cout  (co)
      );

      initial begin
         logic [8:0] exp_v;
         int         lat;
         v = 1'b0; ordy = 1'b0; l = '0; r = '0; ci = 1'b0;
         wait (rst_sw === 1'b1);
         for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            l = 8'($urandom); r = 8'($urandom); ci = 1'($urandom);
            exp_v = {1'b0, l} + {1'b0, r} + {8'd0, ci};
            check($sformatf("sl%0d_op%0d_in_ready", SL, i), 32'(ir), 32'd1);
            v = 1'b1;
            @(posedge clk);
            @(negedge clk);
            v = 1'b0;
            lat = 0;
            while (!ovld && lat < 50) begin
               @(posedge clk);
               @(negedge clk);
               lat++;
            end
            check($sformatf("sl%0d_op%0d_latency", SL, i), 32'(lat), 32'(NS));
            repeat ($urandom_range(0, 3)) begin
               @(posedge clk);
               @(negedge clk);
            end
            check($sformatf("sl%0d_op%0d_valid_held", SL, i), 32'(ovld), 32'd1);
            check($sformatf("sl%0d_op%0d_result", SL, i), 32'({co, s}), 32'(exp_v));
`ifdef SERIAL_ADD_SEQ_OVF_EN
            check($sformatf("sl%0d_op%0d_ovf", SL, i), 32'(ovf),
                  32'((l[7] == r[7]) && (exp_v[7] != l[7])));
`endif
            ordy = 1'b1;
            @(posedge clk);
            @(negedge clk);
            ordy = 1'b0;
         end
         sweep_done++;
      end
   end

endmodule
